ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the RAM_ASYNC single-port memory. It drives the memory ports: address, write data and read/write select, where RDwr=1 means read and RDwr=0 means write on the clk edge. It lets two independent requesters share the memory at up to one access per cycle. After reset it can optionally clear a memory range to zero before accepting traffic.

Parameters:
ADDRESS_SIZE, 20, address width in bits.
DATA_WIDTH, 32, data width in bits.
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to ARB.
CLEAR_LAST, 2**ADDRESS_SIZE-1, last address written by the zero-fill sequence.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
p0_req  in  1  port 0 access request (level)
p0_wr  in  1  port 0: 1 = write, 0 = read
p0_addr  in  ADDRESS_SIZE  port 0 address
p0_wdata  in  DATA_WIDTH  port 0 write data
p0_gnt  out  1  port 0 request accepted (1-cycle pulse)
p0_rvalid  out  1  port 0 read data valid (1-cycle pulse)
p0_rdata  out  DATA_WIDTH  port 0 read data
p1_req, p1_wr, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0
ram_addr  out  ADDRESS_SIZE  to RAM addressBus
ram_din  out  DATA_WIDTH  to RAM dataBus_IN
ram_rdwr  out  1  to RAM RDwr (1 read, 0 write)
ram_dout  in  DATA_WIDTH  from RAM dataBus_OUT (asynchronous read)
busy  out  1  high while zero-fill runs

Behaviour:
- Reset (rst==0 at an edge): all outputs registered and forced.
  - gnt, rvalid: 0. rdata, ram_addr, ram_din: 0. ram_rdwr: 1.
  - busy: CLEAR_ON_RESET.
  - State goes to CLEAR if CLEAR_ON_RESET, else ARB. RR pointer favours port 0.
- State CLEAR:
  - Each cycle presents ram_addr=clr_cnt, ram_din=0, ram_rdwr=0. clr_cnt runs 0..CLEAR_LAST.
  - After presenting CLEAR_LAST: next edge goes to ARB, busy=0, ram_rdwr=1.
  - Requests are ignored in CLEAR; no gnt.
- State ARB, eligibility at edge k: port x is eligible if px_req==1 and px_gnt==0 at that edge. The gnt-high cycle is the requester's drop window.
- Arbitration:
  - Both ports eligible: grant the port not granted most recently, then update the pointer.
  - One port eligible: grant it; the pointer still updates.
- Command timing: after edge k, for the winner, the block drives for exactly one cycle:
  - px_gnt=1; ram_addr=px_addr;
  - for a write, ram_din=px_wdata and ram_rdwr=0;
  - for a read, ram_rdwr=1.
- Write commit: the RAM commits the write at edge k+1.
- Read return: at edge k+1, ram_dout is captured into px_rdata and px_rvalid=1 for one cycle. Read latency is 2 edges from request sample to rvalid.
- Idle cycle (no eligible port): ram_rdwr=1; ram_addr and ram_din hold their last values; no gnt.
- Throughput: 1 access/cycle aggregate. A single port alone gets at most 1 access every 2 cycles.
- Ordering: a read issued the cycle after a write to the same address returns the new data.
- px_rdata holds its value until the next read for that port.
- Reset mid-CLEAR restarts the fill at address 0. Reset during an in-flight read suppresses its rvalid.
- Requester contract: hold req, wr, addr and wdata stable until it samples gnt=1.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum {CLEAR, ARB};
  - constants RDWR_READ=1'b1, RDWR_WRITE=1'b0.
- Sub-module rr_arb2: 2-way round-robin pick.
  - Inputs: clk, rst, two eligible bits, advance.
  - Outputs: one-hot grant and registered last-grant pointer.

Test Plan:
- CLEAR_ON_RESET=1, ADDRESS_SIZE=4, CLEAR_LAST=15; release rst -> busy=1 for exactly 16 cycles with ram_rdwr=0 and ram_addr 0..15; p0_req held high gets no gnt until busy=0; then every address reads 0.
- CLEAR_ON_RESET=0; p0 write addr 5 data 0xA5A5 -> p0_gnt pulse with ram_addr=5, ram_din=0xA5A5, ram_rdwr=0 for one cycle; next p0 read addr 5 -> p0_rvalid two edges after the request sample, p0_rdata=0xA5A5.
- p0 and p1 both requesting continuously, reads of addr 1 and 2 holding 0x11 and 0x22 -> gnt alternates p0,p1,p0,p1 every cycle; each rdata is correct; no cycle has both gnts.
- p1 alone holds req for 3 accesses -> gnt on cycles 1, 3, 5 only; ram_rdwr=1 on idle cycles.
- Same-cycle race: p1 writes 0x77 to addr 3, p0 reads addr 3 on the next grant -> p0_rdata=0x77.
- rst asserted during the CLEAR fill at clr_cnt=7 -> after release the fill restarts at address 0. rst asserted the cycle after a read gnt -> no rvalid; outputs at reset values.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access arbiter and its round-robin picker.
package ram_ctrl_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      ARB   = 1'b1
   } ctrlState_t;

   localparam logic RDWR_READ  = 1'b1;
   localparam logic RDWR_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant from the eligible bits, with the
// registered pointer remembering which port won the most recent arbitration.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] eligible,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       lastGnt
);

   always_comb begin
      grant = 2'b00;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = lastGnt ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer resets to "port 1 went last" so port 0 wins the first contest.
   always_ff @(posedge clk) begin
      if (!rst)
         lastGnt <= 1'b1;
      else if (advance && |eligible)
         lastGnt <= grant[1];
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin sequencer sharing one async-read single-port RAM between two
// requesters, with an optional zero-fill of the RAM after reset.
module ram_access_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int          ADDRESS_SIZE   = 20,
   parameter int          DATA_WIDTH     = 32,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter int unsigned CLEAR_LAST     = 2**ADDRESS_SIZE - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    p0_req,
   input  logic                    p0_wr,
   input  logic [ADDRESS_SIZE-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0]   p0_wdata,
   output logic                    p0_gnt,
   output logic                    p0_rvalid,
   output logic [DATA_WIDTH-1:0]   p0_rdata,
   input  logic                    p1_req,
   input  logic                    p1_wr,
   input  logic [ADDRESS_SIZE-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0]   p1_wdata,
   output logic                    p1_gnt,
   output logic                    p1_rvalid,
   output logic [DATA_WIDTH-1:0]   p1_rdata,
   output logic [ADDRESS_SIZE-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_din,
   output logic                    ram_rdwr,
   input  logic [DATA_WIDTH-1:0]   ram_dout,
   output logic                    busy
);

   localparam logic [ADDRESS_SIZE-1:0] CLR_LAST_A = ADDRESS_SIZE'(CLEAR_LAST);

   ctrlState_t state, stateNxt;

   logic [1:0]                   req, wr, eligible, grant;
   logic [1:0][ADDRESS_SIZE-1:0] addr;
   logic [1:0][DATA_WIDTH-1:0]   wdata;
   logic                         win, lastGnt, advance;

   logic [1:0]                   gnt, gntNxt, rvalid, rvalidNxt;
   logic [1:0][DATA_WIDTH-1:0]   rdata, rdataNxt;
   logic                         rdPend, rdPendNxt;
   logic [ADDRESS_SIZE-1:0]      clrCnt, clrCntNxt, ramAddrNxt;
   logic                         clrDone, clrDoneNxt;
   logic [DATA_WIDTH-1:0]        ramDinNxt;
   logic                         ramRdwrNxt, busyNxt;

   assign req   = {p1_req, p0_req};
   assign wr    = {p1_wr, p0_wr};
   assign addr  = {p1_addr, p0_addr};
   assign wdata = {p1_wdata, p0_wdata};

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign p0_rvalid = rvalid[0];
   assign p1_rvalid = rvalid[1];
   assign p0_rdata  = rdata[0];
   assign p1_rdata  = rdata[1];

   // The gnt-high cycle is the requester's window to drop or change its request.
   assign eligible = req & ~gnt;
   assign advance  = (state == ARB);
   assign win      = grant[1];

   rr_arb2 uArb (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
      .advance  (advance),
      .grant    (grant),
      .lastGnt  (lastGnt)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= CLEAR_ON_RESET ? CLEAR : ARB;
      else
         state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         CLEAR:   stateNxt = clrDone ? ARB : CLEAR;
         default: stateNxt = ARB;
      endcase
   end

   always_comb begin
      gntNxt     = '0;
      rvalidNxt  = '0;
      rdataNxt   = rdata;
      rdPendNxt  = 1'b0;
      ramAddrNxt = ram_addr;
      ramDinNxt  = ram_din;
      ramRdwrNxt = RDWR_READ;
      busyNxt    = 1'b0;
      clrCntNxt  = clrCnt;
      clrDoneNxt = clrDone;

      // The pointer already names the port whose read is on the bus.
      if (rdPend) begin
         rvalidNxt[lastGnt] = 1'b1;
         rdataNxt[lastGnt]  = ram_dout;
      end

      case (state)
         CLEAR: begin
            if (!clrDone) begin
               busyNxt    = 1'b1;
               ramAddrNxt = clrCnt;
               ramDinNxt  = '0;
               ramRdwrNxt = RDWR_WRITE;
               clrCntNxt  = clrCnt + ADDRESS_SIZE'(1);
               clrDoneNxt = (clrCnt == CLR_LAST_A);
            end
         end
         default: begin
            if (|grant) begin
               gntNxt[win] = 1'b1;
               ramAddrNxt  = addr[win];
               if (wr[win]) begin
                  ramDinNxt  = wdata[win];
                  ramRdwrNxt = RDWR_WRITE;
               end else begin
                  rdPendNxt = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt      <= '0;
         rvalid   <= '0;
         rdata    <= '0;
         rdPend   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_rdwr <= RDWR_READ;
         busy     <= CLEAR_ON_RESET;
         clrCnt   <= '0;
         clrDone  <= 1'b0;
      end else begin
         gnt      <= gntNxt;
         rvalid   <= rvalidNxt;
         rdata    <= rdataNxt;
         rdPend   <= rdPendNxt;
         ram_addr <= ramAddrNxt;
         ram_din  <= ramDinNxt;
         ram_rdwr <= ramRdwrNxt;
         busy     <= busyNxt;
         clrCnt   <= clrCntNxt;
         clrDone  <= clrDoneNxt;
      end
   end

endmodule
